// File: rtl/tcp_pkg.sv
// Shared TCP definitions for the receive and transmit segment paths:
// segment geometry, flag bits, header field offsets, connection states, pseudo-header.
package tcp_pkg;
    localparam int PAYLOAD_LEN       = 262;
    localparam int TCPH_LEN          = 20;
    localparam int PSEUDO_HEADER_LEN = 12;
    localparam int PROTOCOL          = 6;

    localparam logic [31:0] SRCADDR    = 32'h7f000001;
    localparam logic [31:0] DESADDR    = 32'h7f000001;
    localparam logic [15:0] LOCAL_PORT = 16'd9000;
    localparam logic [31:0] ISS        = 32'h00001000;

    localparam int SEG_W      = (PAYLOAD_LEN + TCPH_LEN) * 8;
    localparam int PAY_W      = PAYLOAD_LEN * 8;
    localparam int PSEUDO_W   = PSEUDO_HEADER_LEN * 8;
    localparam int CSUM_W     = PSEUDO_W + SEG_W;
    localparam int CSUM_WORDS = CSUM_W / 16;
    localparam logic [7:0] CSUM_LAST = 8'(CSUM_WORDS - 1);

    localparam logic [5:0] FLAG_FIN  = 6'd1;
    localparam logic [5:0] FLAG_SYN  = 6'd2;
    localparam logic [5:0] FLAG_RST  = 6'd4;
    localparam logic [5:0] FLAG_PUSH = 6'd8;
    localparam logic [5:0] FLAG_ACK  = 6'd16;
    localparam logic [5:0] FLAG_URG  = 6'd32;

    localparam int OFF_SRC_PORT = 0;
    localparam int OFF_DST_PORT = 16;
    localparam int OFF_SEQ      = 32;
    localparam int OFF_ACK      = 64;
    localparam int OFF_HDRLEN   = 96;
    localparam int OFF_FLAGS    = 106;
    localparam int OFF_WINDOW   = 112;
    localparam int OFF_CSUM     = 128;
    localparam int OFF_URGENT   = 144;
    localparam int OFF_PAYLOAD  = 160;

    typedef enum logic [1:0] {
        CONN_LISTEN      = 2'd0,
        CONN_SYN_RCVD    = 2'd1,
        CONN_ESTABLISHED = 2'd2
    } conn_state_e;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_SUM  = 2'd1,
        P_EVAL = 2'd2
    } proc_state_e;

    // {length, protocol, zero, DESADDR, SRCADDR}, SRCADDR in the low bits
    function automatic logic [PSEUDO_W-1:0] pseudo_header();
        return {16'(TCPH_LEN + PAYLOAD_LEN), 8'(PROTOCOL), 8'd0, DESADDR, SRCADDR};
    endfunction
endpackage

// File: rtl/tcp_rx_csum_serial.sv
// 16-bit one's-complement accumulator with end-around carry, one word per enabled cycle.
module csum_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [15:0] i_word,
    output logic [15:0] o_sum
);
    logic [15:0] r_acc;
    logic [16:0] w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 16'd0;
        end else if (i_clr) begin
            r_acc <= 16'd0;
        end else if (i_en) begin
            r_acc <= w_sum[15:0] + {15'd0, w_sum[16]};
        end
    end

    assign o_sum = r_acc;
endmodule

// File: rtl/tcp_rx.sv
// Passive-open TCP receive endpoint: serial checksum, connection FSM, payload delivery
// and reply requests. Decisions made in P_EVAL are staged one cycle before reaching the outputs.
//
// state  | meaning
// P_IDLE | ready for a segment
// P_SUM  | summing one checksum word per cycle
// P_EVAL | checksum final, segment acted on
module tcp_rx
    import tcp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [SEG_W-1:0] rx_tcp_data,
    output logic             tx_fix_valid,
    output logic [PAY_W-1:0] tx_fix_data,
    output logic             reply_req,
    output logic [5:0]       reply_flag,
    output logic [31:0]      reply_seq,
    output logic [31:0]      reply_ack,
    output logic [1:0]       conn_state,
    output logic [15:0]      drop_cnt
);
    proc_state_e r_state, w_state_nxt;
    logic [SEG_W-1:0]  r_seg;
    logic [7:0]        r_idx;
    logic [CSUM_W-1:0] w_csum_data;
    logic [15:0]       w_word, w_acc;
    logic              w_accept, w_sum_en, w_valid;
    logic [5:0]        w_flags;
    logic [31:0]       w_seq, w_ack;

    logic              w_ev_fix, w_ev_reply, w_ev_drop;
    logic [5:0]        w_ev_flag;
    logic [31:0]       w_ev_seq, w_ev_ack, w_ev_rcv;
    conn_state_e       w_ev_conn;

    logic              r_pend, r_pend_fix, r_pend_reply, r_pend_drop;
    logic [5:0]        r_pend_flag;
    logic [31:0]       r_pend_seq, r_pend_ack, r_pend_rcv;
    conn_state_e       r_pend_conn;

    logic              r_fix_valid, r_reply_req;
    logic [PAY_W-1:0]  r_fix_data;
    logic [5:0]        r_reply_flag;
    logic [31:0]       r_reply_seq, r_reply_ack, r_rcv_nxt;
    logic [15:0]       r_drop_cnt;
    conn_state_e       r_conn;

    assign w_csum_data = {pseudo_header(), r_seg};
    assign w_word      = w_csum_data[{r_idx, 4'b0000} +: 16];
    assign w_flags     = r_seg[OFF_FLAGS +: 6];
    assign w_seq       = r_seg[OFF_SEQ +: 32];
    assign w_ack       = r_seg[OFF_ACK +: 32];
    assign w_valid     = (w_acc == 16'hFFFF) && (r_seg[OFF_DST_PORT +: 16] == LOCAL_PORT);

    csum_serial u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_accept),
        .i_en   (w_sum_en),
        .i_word (w_word),
        .o_sum  (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= P_IDLE;
            r_idx   <= 8'd0;
            r_seg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_seg <= rx_tcp_data;
                r_idx <= 8'd0;
            end else if (w_sum_en) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            P_IDLE:  if (rx_valid) w_state_nxt = P_SUM;
            P_SUM:   if (r_idx == CSUM_LAST) w_state_nxt = P_EVAL;
            P_EVAL:  w_state_nxt = P_IDLE;
            default: w_state_nxt = P_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == P_IDLE) && rx_valid;
        w_sum_en   = (r_state == P_SUM);
        w_ev_fix   = 1'b0;
        w_ev_reply = 1'b0;
        w_ev_drop  = 1'b0;
        w_ev_flag  = 6'd0;
        w_ev_seq   = ISS + 32'd1;
        w_ev_ack   = r_rcv_nxt;
        w_ev_rcv   = r_rcv_nxt;
        w_ev_conn  = r_conn;
        if (!w_valid) begin
            w_ev_drop = 1'b1;
        end else if ((w_flags & FLAG_RST) != 6'd0) begin
            w_ev_conn = CONN_LISTEN;
        end else if (r_conn == CONN_LISTEN && w_flags == FLAG_SYN) begin
            w_ev_rcv   = w_seq + 32'd1;
            w_ev_conn  = CONN_SYN_RCVD;
            w_ev_reply = 1'b1;
            w_ev_flag  = FLAG_SYN | FLAG_ACK;
            w_ev_seq   = ISS;
            w_ev_ack   = w_seq + 32'd1;
        end else if (r_conn == CONN_SYN_RCVD && (w_flags & FLAG_ACK) != 6'd0
                     && w_ack == ISS + 32'd1) begin
            w_ev_conn = CONN_ESTABLISHED;
        end else if (r_conn == CONN_ESTABLISHED && (w_flags & FLAG_FIN) != 6'd0) begin
            w_ev_rcv   = r_rcv_nxt + 32'd1;
            w_ev_reply = 1'b1;
            w_ev_flag  = FLAG_FIN | FLAG_ACK;
            w_ev_ack   = r_rcv_nxt + 32'd1;
            w_ev_conn  = CONN_LISTEN;
        end else if (r_conn == CONN_ESTABLISHED && (w_flags & FLAG_PUSH) != 6'd0) begin
            w_ev_reply = 1'b1;
            w_ev_flag  = FLAG_ACK;
            if (w_seq == r_rcv_nxt) begin
                w_ev_fix = 1'b1;
                w_ev_rcv = r_rcv_nxt + 32'(PAYLOAD_LEN);
                w_ev_ack = r_rcv_nxt + 32'(PAYLOAD_LEN);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= 1'b0;
            r_pend_fix   <= 1'b0;
            r_pend_reply <= 1'b0;
            r_pend_drop  <= 1'b0;
            r_pend_flag  <= 6'd0;
            r_pend_seq   <= 32'd0;
            r_pend_ack   <= 32'd0;
            r_pend_rcv   <= 32'd0;
            r_pend_conn  <= CONN_LISTEN;
        end else begin
            r_pend <= (r_state == P_EVAL);
            if (r_state == P_EVAL) begin
                r_pend_fix   <= w_ev_fix;
                r_pend_reply <= w_ev_reply;
                r_pend_drop  <= w_ev_drop;
                r_pend_flag  <= w_ev_flag;
                r_pend_seq   <= w_ev_seq;
                r_pend_ack   <= w_ev_ack;
                r_pend_rcv   <= w_ev_rcv;
                r_pend_conn  <= w_ev_conn;
            end
        end
    end

    // r_seg is only overwritten by the next accept, which is no earlier than this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fix_valid  <= 1'b0;
            r_fix_data   <= '0;
            r_reply_req  <= 1'b0;
            r_reply_flag <= 6'd0;
            r_reply_seq  <= 32'd0;
            r_reply_ack  <= 32'd0;
            r_rcv_nxt    <= 32'd0;
            r_drop_cnt   <= 16'd0;
            r_conn       <= CONN_LISTEN;
        end else begin
            r_fix_valid <= r_pend && r_pend_fix;
            r_reply_req <= r_pend && r_pend_reply;
            if (r_pend) begin
                r_conn    <= r_pend_conn;
                r_rcv_nxt <= r_pend_rcv;
                if (r_pend_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                if (r_pend_fix) r_fix_data <= r_seg[OFF_PAYLOAD +: PAY_W];
                if (r_pend_reply) begin
                    r_reply_flag <= r_pend_flag;
                    r_reply_seq  <= r_pend_seq;
                    r_reply_ack  <= r_pend_ack;
                end
            end
        end
    end

    assign rx_ready     = (r_state == P_IDLE);
    assign tx_fix_valid = r_fix_valid;
    assign tx_fix_data  = r_fix_data;
    assign reply_req    = r_reply_req;
    assign reply_flag   = r_reply_flag;
    assign reply_seq    = r_reply_seq;
    assign reply_ack    = r_reply_ack;
    assign conn_state   = r_conn;
    assign drop_cnt     = r_drop_cnt;
endmodule

// File: tb/tb_tcp_rx.sv
// Randomized bench for tcp_rx against a segment-level reference model of the connection rules.
module tb_tcp_rx;
    localparam int SEGW = 2256;
    localparam int PAYW = 2096;
    localparam logic [95:0] PSEUDO = {16'd282, 8'd6, 8'd0, 32'h7f000001, 32'h7f000001};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_valid;
    logic            rx_ready;
    logic [SEGW-1:0] rx_tcp_data;
    logic            tx_fix_valid;
    logic [PAYW-1:0] tx_fix_data;
    logic            reply_req;
    logic [5:0]      reply_flag;
    logic [31:0]     reply_seq, reply_ack;
    logic [1:0]      conn_state;
    logic [15:0]     drop_cnt;

    always #5 clk = ~clk;

    tcp_rx dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_tcp_data(rx_tcp_data), .tx_fix_valid(tx_fix_valid), .tx_fix_data(tx_fix_data),
        .reply_req(reply_req), .reply_flag(reply_flag), .reply_seq(reply_seq),
        .reply_ack(reply_ack), .conn_state(conn_state), .drop_cnt(drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]      m_conn;
    logic [31:0]     m_rcv, m_seq, m_ack;
    logic [15:0]     m_drop;
    logic [5:0]      m_flag;
    logic [PAYW-1:0] m_fix;
    logic            m_exp_fix, m_exp_reply;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ones_sum(input logic [2351:0] d);
        int unsigned s = 0;
        for (int i = 0; i < 147; i++) s += 32'(d[i*16 +: 16]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    function automatic logic [SEGW-1:0] make_seg(input logic [15:0] dport, input logic [31:0] seq,
                                                 input logic [31:0] ack, input logic [5:0] flags,
                                                 input logic bad_csum);
        logic [SEGW-1:0] seg = '0;
        logic [15:0] c;
        for (int i = 0; i < 262; i++) seg[160 + i*8 +: 8] = 8'($urandom);
        seg[15:0]    = 16'($urandom);
        seg[31:16]   = dport;
        seg[63:32]   = seq;
        seg[95:64]   = ack;
        seg[99:96]   = 4'd5;
        seg[111:106] = flags;
        seg[127:112] = 16'hFFFF;
        c = ~ones_sum({PSEUDO, seg});
        if (bad_csum) c = c ^ 16'h0001;
        seg[143:128] = c;
        return seg;
    endfunction

    task automatic model_reset();
        m_conn = 2'd0; m_rcv = 32'd0; m_drop = 16'd0;
        m_flag = 6'd0; m_seq = 32'd0; m_ack = 32'd0; m_fix = '0;
        m_exp_fix = 1'b0; m_exp_reply = 1'b0;
    endtask

    task automatic model_reply(input logic [5:0] f, input logic [31:0] s, input logic [31:0] a);
        m_exp_reply = 1'b1; m_flag = f; m_seq = s; m_ack = a;
    endtask

    task automatic model_eval(input logic [SEGW-1:0] seg);
        logic [31:0] seq = seg[63:32];
        logic [31:0] ack = seg[95:64];
        logic [5:0]  fl  = seg[111:106];
        logic ok = (ones_sum({PSEUDO, seg}) == 16'hFFFF) && (seg[31:16] == 16'd9000);
        m_exp_fix = 1'b0; m_exp_reply = 1'b0;
        if (!ok) begin
            if (m_drop != 16'hFFFF) m_drop++;
        end else if (fl[2]) begin
            m_conn = 2'd0;
        end else if (m_conn == 2'd0 && fl == 6'd2) begin
            m_rcv = seq + 32'd1; m_conn = 2'd1;
            model_reply(6'd18, 32'h1000, seq + 32'd1);
        end else if (m_conn == 2'd1 && fl[4] && ack == 32'h1001) begin
            m_conn = 2'd2;
        end else if (m_conn == 2'd2 && fl[0]) begin
            m_rcv = m_rcv + 32'd1; m_conn = 2'd0;
            model_reply(6'd17, 32'h1001, m_rcv);
        end else if (m_conn == 2'd2 && fl[3] && seq == m_rcv) begin
            m_exp_fix = 1'b1; m_fix = seg[SEGW-1:160]; m_rcv = m_rcv + 32'd262;
            model_reply(6'd16, 32'h1001, m_rcv);
        end else if (m_conn == 2'd2 && fl[3]) begin
            model_reply(6'd16, 32'h1001, m_rcv);
        end
    endtask

    task automatic run_seg(input logic [SEGW-1:0] seg);
        int w = 0;
        while (!rx_ready && w < 300) begin @(negedge clk); w++; end
        check_eq("ready_before", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rx_valid = 1'b1; rx_tcp_data = seg;
        @(posedge clk);
        #1 rx_valid = 1'b0; rx_tcp_data = ~seg;
        model_eval(seg);
        repeat (147) @(posedge clk);
        #1;
        check_eq("busy_eval", 64'(rx_ready), 64'd0);
        check_eq("early_reply", 64'({reply_req, tx_fix_valid}), 64'd0);
        @(posedge clk);
        #1;
        check_eq("ready_again", 64'(rx_ready), 64'd1);
        check_eq("early_reply2", 64'({reply_req, tx_fix_valid}), 64'd0);
        @(posedge clk);
        #1;
        check_eq("reply_req", 64'(reply_req), 64'(m_exp_reply));
        check_eq("fix_valid", 64'(tx_fix_valid), 64'(m_exp_fix));
        check_eq("fix_data", 64'(tx_fix_data == m_fix), 64'd1);
        check_eq("conn_state", 64'(conn_state), 64'(m_conn));
        check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check_eq("reply_fields", {26'd0, reply_flag, reply_seq}, {26'd0, m_flag, m_seq});
        check_eq("reply_ack", 64'(reply_ack), 64'(m_ack));
        @(posedge clk);
        #1;
        check_eq("pulse_width", 64'({reply_req, tx_fix_valid}), 64'd0);
    endtask

    task automatic check_reset_state();
        check_eq("rst_ready", 64'(rx_ready), 64'd1);
        check_eq("rst_pulses", 64'({reply_req, tx_fix_valid}), 64'd0);
        check_eq("rst_conn_drop", {46'd0, conn_state, drop_cnt}, 64'd0);
        check_eq("rst_reply", {26'd0, reply_flag, reply_seq}, 64'd0);
        check_eq("rst_reply_ack", 64'(reply_ack), 64'd0);
        check_eq("rst_fix_data", 64'(tx_fix_data == '0), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SEGW-1:0] seg;
        logic [5:0]      fl;
        logic [31:0]     sq, ak;
        logic [15:0]     dp;
        int              seen;

        rst_n = 1'b0; rx_valid = 1'b0; rx_tcp_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_reset_state();

        run_seg(make_seg(16'd9000, 32'h00000100, 32'h0, 6'd2, 1'b0));
        run_seg(make_seg(16'd9000, 32'h00000101, 32'h00001001, 6'd16, 1'b0));
        run_seg(make_seg(16'd9000, 32'h00000101, 32'h00001001, 6'd24, 1'b0));
        run_seg(make_seg(16'd9000, 32'h00000207, 32'h00001001, 6'd24, 1'b1));
        run_seg(make_seg(16'd9001, 32'h00000207, 32'h00001001, 6'd24, 1'b0));
        run_seg(make_seg(16'd9000, 32'h00000207, 32'h00001001, 6'd17, 1'b0));
        run_seg(make_seg(16'd9000, 32'hFFFFFF7F, 32'h0, 6'd2, 1'b0));
        run_seg(make_seg(16'd9000, 32'hFFFFFF80, 32'h00001001, 6'd16, 1'b0));
        run_seg(make_seg(16'd9000, 32'hFFFFFF80, 32'h00001001, 6'd24, 1'b0));
        run_seg(make_seg(16'd9000, 32'h00000000, 32'h00001001, 6'd24, 1'b0));
        run_seg(make_seg(16'd9000, 32'h00000500, 32'h0, 6'd2, 1'b0));
        run_seg(make_seg(16'd9000, 32'h00000501, 32'h0, 6'd4, 1'b0));

        // reset in the middle of summing a SYN: nothing may come out of it
        run_seg(make_seg(16'd9000, 32'h00000600, 32'h0, 6'd2, 1'b0));
        @(negedge clk);
        rx_valid = 1'b1; rx_tcp_data = make_seg(16'd9000, 32'h00000700, 32'h0, 6'd24, 1'b0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (59) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_state();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 if (reply_req || tx_fix_valid) seen++;
        end
        check_eq("no_pulse_after_reset", 64'(seen), 64'd0);
        check_reset_state();

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: fl = 6'd2;
                1: fl = 6'd16;
                2: fl = 6'd24;
                3: fl = 6'd17;
                4: fl = 6'd4;
                default: fl = 6'($urandom);
            endcase
            if (m_conn == 2'd0 && $urandom_range(0, 1) == 0) fl = 6'd2;
            if (m_conn == 2'd1 && $urandom_range(0, 1) == 0) fl = 6'd16;
            if (m_conn == 2'd2 && $urandom_range(0, 3) != 0) fl = 6'd24;
            case ($urandom_range(0, 3))
                0, 1: sq = m_rcv;
                2: sq = m_rcv - 32'd1;
                default: sq = $urandom;
            endcase
            ak = ($urandom_range(0, 3) != 0) ? 32'h00001001 : $urandom;
            dp = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'd9000;
            seg = make_seg(dp, sq, ak, fl, $urandom_range(0, 7) == 0);
            run_seg(seg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tcp_rx.md
# tcp_rx

Receive-side TCP endpoint that accepts complete inbound segments, verifies the one's-complement checksum serially over pseudo-header plus segment, and runs a passive-open connection FSM (LISTEN, SYN_RCVD, ESTABLISHED). In-order payload is delivered to the FIX layer. Reply requests (flag, seq, ack) go to the segment transmitter, which builds and checksums the outgoing segment. It sits between the network ingress and the FIX parser, mirroring the transmit path.

## Interface
- PAYLOAD_LEN, 262: payload bytes per segment.
- TCPH_LEN, 20: TCP header bytes; no options.
- PSEUDO_HEADER_LEN, 12: pseudo-header bytes.
- PROTOCOL, 6: pseudo-header protocol byte.
- SRCADDR, 32'h7f000001: remote IP.
- DESADDR, 32'h7f000001: local IP.
- LOCAL_PORT, 16'd9000: accepted destination port.
- ISS, 32'h00001000: local initial sequence number.

Ports:
- clk, in, 1: single clock; one clock domain only.
- rst_n, in, 1: asynchronous, active-low reset.
- rx_valid, in, 1: segment present on rx_tcp_data.
- rx_ready, out, 1: block can accept a segment; combinational, high only in P_IDLE.
- rx_tcp_data, in, (PAYLOAD_LEN+TCPH_LEN)*8: inbound segment.
- tx_fix_valid, out, 1: one-cycle pulse when tx_fix_data holds a new payload.
- tx_fix_data, out, PAYLOAD_LEN*8: delivered payload.
- reply_req, out, 1: one-cycle pulse requesting an outbound segment.
- reply_flag, out, 6: flags for the outbound segment.
- reply_seq, out, 32: sequence number for the outbound segment.
- reply_ack, out, 32: acknowledgement number for the outbound segment.
- conn_state, out, 2: 0 LISTEN, 1 SYN_RCVD, 2 ESTABLISHED.
- drop_cnt, out, 16: saturating count of segments dropped for bad checksum or wrong port.

## Operation
- Segment field bit ranges:
  - src port [15:0], dst port [31:16], seq [63:32], ack [95:64]
  - hdrlen [99:96], reserved [105:100], flags [111:106], window [127:112]
  - checksum [143:128], urgent pointer [159:144], payload [top:160]
- Flag bits: FIN 1, SYN 2, RST 4, PUSH 8, ACK 16, URG 32.
- Pseudo-header bit ranges: SRCADDR [31:0], DESADDR [63:32], zero [71:64], PROTOCOL [79:72], TCPH_LEN+PAYLOAD_LEN [95:80].
- Checksum data is {pseudo, segment}, split into 16-bit words. Word 0 is the least-significant 16 bits. With defaults that is 147 words; the index counter is 8 bits wide.
- Accumulation, one word per cycle: s = acc + w (17 bits); acc <= s[15:0] + s[16]. acc starts at 0.
- The segment is valid iff the final acc == 16'hFFFF and dst port == LOCAL_PORT.
- Processing FSM:
  - P_IDLE -> P_SUM on rx_valid&&rx_ready; the segment is latched.
  - P_SUM -> P_EVAL after the last word.
  - P_EVAL -> P_IDLE.
- P_EVAL actions, first match wins:
  - Invalid segment: drop and increment drop_cnt (saturating at 16'hFFFF); conn_state unchanged.
  - RST set: conn -> LISTEN, no reply.
  - LISTEN and flags==SYN: rcv_nxt = seq+1; conn -> SYN_RCVD; reply SYN|ACK, seq=ISS, ack=seq+1.
  - SYN_RCVD and ACK set and ack==ISS+1: conn -> ESTABLISHED, no reply.
  - ESTABLISHED and FIN set: rcv_nxt += 1; reply FIN|ACK, seq=ISS+1, ack=new rcv_nxt; conn -> LISTEN.
  - ESTABLISHED and PUSH set and seq==rcv_nxt: pulse tx_fix_valid with the payload; rcv_nxt += PAYLOAD_LEN (mod 2^32); reply ACK, seq=ISS+1, ack=new rcv_nxt.
  - ESTABLISHED and PUSH set and seq!=rcv_nxt: no delivery; duplicate ACK with ack=rcv_nxt.
  - Otherwise: ignore silently.
- All sequence arithmetic is mod 2^32; wrap is legal.

## Timing
- Reset values:
  - 0: tx_fix_valid, tx_fix_data, reply_req, reply_flag, reply_seq, reply_ack, drop_cnt, rcv_nxt
  - conn_state = LISTEN; processing state = P_IDLE, so rx_ready = 1.
- Latency from the accept edge E:
  - Words are summed on edges E+1..E+147.
  - P_EVAL is the cycle after E+147.
  - Registered outputs update on edge E+149 and pulse for exactly one cycle.
  - rx_ready is high again in the cycle after edge E+148.
- Throughput: one segment per 149 cycles. rx_valid is ignored while rx_ready=0; the upstream holds the segment.
- rx_tcp_data may change after the accept edge; the latched copy is used.
- reset mid-P_SUM or P_EVAL: segment discarded, no pulses, all registers return to reset values.

## Structure
- Shared package tcp_pkg holds:
  - flag localparams and header field offsets
  - the conn_state encoding
  - the pseudo-header layout
- These are shared with the transmit-side block.
- Sub-module csum_serial: 16-bit end-around-carry accumulator with clear and enable inputs and a 16-bit output.

## Test plan
- SYN seq=32'h00000100, valid checksum -> reply_req with SYN|ACK, seq=32'h1000, ack=32'h101; conn_state=1 at E+149.
- Then ACK with ack=32'h1001 -> conn_state=2, no reply_req. Then PUSH|ACK seq=32'h101 -> tx_fix_valid pulse with the payload; reply ACK ack=32'h207.
- PUSH segment with the checksum field XOR 16'h0001 -> no tx_fix_valid, no reply; drop_cnt increments by 1. Same check for dst port 9001.
- ESTABLISHED, rcv_nxt=32'hFFFFFF80, PUSH seq=32'hFFFFFF80 -> ack wraps to 32'h00000086. Then seq=32'h0 -> duplicate ACK with ack=32'h86, no delivery.
- FIN in ESTABLISHED -> FIN|ACK with ack=rcv_nxt+1; conn_state=0. RST in SYN_RCVD -> conn_state=0, no reply.
- rst_n low at E+60 -> all outputs at reset values, rx_ready=1, no pulse at E+149.
